// File: rtl/hilo_muldiv_if.sv
// EX-stage handshake between the ID/EX register and the HI/LO multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface hilo_muldiv_if;
    logic        ID_EXE_MulDivEn;
    logic [5:0]  ID_EXE_Func;
    logic [31:0] ID_EXE_Rs;
    logic [31:0] ID_EXE_Rt;
    logic        MulDivStall;
    logic [31:0] HiLoOut;
    logic        MulDivBusy;
    logic        DivByZero;

    modport master (
        output ID_EXE_MulDivEn,
        output ID_EXE_Func,
        output ID_EXE_Rs,
        output ID_EXE_Rt,
        input  MulDivStall,
        input  HiLoOut,
        input  MulDivBusy,
        input  DivByZero
    );

    modport slave (
        input  ID_EXE_MulDivEn,
        input  ID_EXE_Func,
        input  ID_EXE_Rs,
        input  ID_EXE_Rt,
        output MulDivStall,
        output HiLoOut,
        output MulDivBusy,
        output DivByZero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and
// restoring divide, with mfhi/mflo/mthi/mtlo handled in a single cycle.
module hilo_muldiv_unit (
    input logic          clk,
    input logic          rst_n,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic [63:0] r_work;
    logic [31:0] r_opb;
    logic [31:0] r_rs;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dbz;

    logic        w_en;
    logic [5:0]  w_fn;
    logic        w_op_mul;
    logic        w_op_div;
    logic        w_start;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_last;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [63:0] w_prod;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_next;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_en     = bus.ID_EXE_MulDivEn;
    assign w_fn     = bus.ID_EXE_Func;
    assign w_op_mul = w_en && (w_fn == F_MULT || w_fn == F_MULTU);
    assign w_op_div = w_en && (w_fn == F_DIV || w_fn == F_DIVU);
    assign w_start  = w_op_mul || w_op_div;
    // mult and div have an even funct; the unsigned variants are odd
    assign w_signed = ~w_fn[0];
    assign w_a_neg  = w_signed & bus.ID_EXE_Rs[31];
    assign w_b_neg  = w_signed & bus.ID_EXE_Rt[31];
    assign w_a_mag  = w_a_neg ? -bus.ID_EXE_Rs : bus.ID_EXE_Rs;
    assign w_b_mag  = w_b_neg ? -bus.ID_EXE_Rt : bus.ID_EXE_Rt;
    assign w_last   = (r_cnt == 6'd31);

    // r_work holds {accumulator, multiplier} when multiplying
    assign w_mul_sum  = {1'b0, r_work[63:32]}
                      + (r_work[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_work[31:1]};
    assign w_prod     = r_neg_res ? -w_mul_next : w_mul_next;

    // r_work holds {partial remainder, dividend/quotient} when dividing
    assign w_div_trial = {r_work[63:32], r_work[31]} - {1'b0, r_opb};
    assign w_div_next  = w_div_trial[32]
                       ? {r_work[62:0], 1'b0}
                       : {w_div_trial[31:0], r_work[30:0], 1'b1};
    assign w_quo = r_neg_res ? -w_div_next[31:0] : w_div_next[31:0];
    assign w_rem = r_neg_rem ? -w_div_next[63:32] : w_div_next[63:32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        bus.MulDivStall = 1'b0;
        bus.MulDivBusy  = 1'b0;
        bus.DivByZero   = 1'b0;
        bus.HiLoOut     = 32'd0;
        unique case (r_state)
            S_IDLE: begin
                bus.MulDivStall = w_start;
                if (w_op_mul) begin
                    w_next = S_MUL;
                end else if (w_op_div) begin
                    w_next = S_DIV;
                end
                if (w_en && w_fn == F_MFHI) begin
                    bus.HiLoOut = r_hi;
                end else if (w_en && w_fn == F_MFLO) begin
                    bus.HiLoOut = r_lo;
                end
            end
            S_MUL, S_DIV: begin
                bus.MulDivStall = 1'b1;
                bus.MulDivBusy  = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.DivByZero = r_dbz;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // an in-flight op must not hold the pipeline while reset is asserted
        if (!rst_n) begin
            bus.MulDivStall = 1'b0;
            bus.MulDivBusy  = 1'b0;
            bus.DivByZero   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_cnt     <= 6'd0;
            r_work    <= 64'd0;
            r_opb     <= 32'd0;
            r_rs      <= 32'd0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_work    <= {32'd0, w_a_mag};
                        r_opb     <= w_b_mag;
                        r_rs      <= bus.ID_EXE_Rs;
                        r_cnt     <= 6'd0;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= w_op_div && (bus.ID_EXE_Rt == 32'd0);
                    end else if (w_en && w_fn == F_MTHI) begin
                        r_hi <= bus.ID_EXE_Rs;
                    end else if (w_en && w_fn == F_MTLO) begin
                        r_lo <= bus.ID_EXE_Rs;
                    end
                end
                S_MUL: begin
                    r_work <= w_mul_next;
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                S_DIV: begin
                    r_work <= w_div_next;
                    r_cnt  <= r_cnt + 6'd1;
                    if (w_last) begin
                        if (r_dbz) begin
                            r_hi <= r_rs;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt <= r_cnt;
                end
                default: begin
                    r_cnt <= 6'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed checks of hilo_muldiv_unit: mult/div results, stall length,
// divide-by-zero pulse, mthi/mfhi bypass and reset abort.
module tb_hilo_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    hilo_muldiv_if bus ();

    hilo_muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
        bus.ID_EXE_MulDivEn = en;
        bus.ID_EXE_Func     = fn;
        bus.ID_EXE_Rs       = rs;
        bus.ID_EXE_Rt       = rt;
    endtask

    // issue a mult/div op at a negedge and hold it while stalled
    task automatic run_op(input string tag, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int exp_dbz);
        int stalls;
        int dbz;
        stalls = 0;
        dbz    = 0;
        @(negedge clk);
        drive(1'b1, fn, rs, rt);
        #1;
        while (bus.MulDivStall === 1'b1 && stalls < 100) begin
            stalls++;
            if (stalls == 5) chk({tag, "_busy"}, 32'(bus.MulDivBusy), 32'd1);
            @(negedge clk);
            #1;
        end
        chk({tag, "_stall"}, 32'(stalls), 32'd33);
        chk({tag, "_busy_done"}, 32'(bus.MulDivBusy), 32'd0);
        if (bus.DivByZero === 1'b1) dbz++;
        @(negedge clk);
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        #1;
        if (bus.DivByZero === 1'b1) dbz++;
        chk({tag, "_dbz"}, 32'(dbz), 32'(exp_dbz));
    endtask

    task automatic rd(input string tag, input logic [5:0] fn,
                      input logic [31:0] exp);
        @(negedge clk);
        drive(1'b1, fn, 32'h5555_5555, 32'h0);
        #1;
        chk({tag, "_val"}, bus.HiLoOut, exp);
        chk({tag, "_nostall"}, 32'(bus.MulDivStall), 32'd0);
        @(negedge clk);
        drive(1'b0, 6'h00, 32'd0, 32'd0);
    endtask

    task automatic op_res(input string tag, input logic [5:0] fn,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int exp_dbz);
        run_op(tag, fn, rs, rt, exp_dbz);
        rd({tag, "_hi"}, 6'h10, ehi);
        rd({tag, "_lo"}, 6'h12, elo);
    endtask

    initial begin
        int stalls;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(bus.MulDivStall), 32'd0);
        chk("rst_busy", 32'(bus.MulDivBusy), 32'd0);
        chk("rst_dbz", 32'(bus.DivByZero), 32'd0);
        chk("rst_out", bus.HiLoOut, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst_hi", 6'h10, 32'd0);
        rd("rst_lo", 6'h12, 32'd0);

        op_res("multu", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 0);
        op_res("mult", 6'h18, 32'hFFFF_FFFD, 32'h0000_0007,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        op_res("mult_min", 6'h18, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 0);
        op_res("div", 6'h1A, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        op_res("divu", 6'h1B, 32'h0000_0007, 32'h0000_0002,
               32'h0000_0001, 32'h0000_0003, 0);
        op_res("div_neg_rt", 6'h1A, 32'd100, 32'hFFFF_FFF9,
               32'h0000_0002, 32'hFFFF_FFF2, 0);
        op_res("divu_zero", 6'h1B, 32'h0000_1234, 32'h0,
               32'h0000_1234, 32'hFFFF_FFFF, 1);
        op_res("div_zero", 6'h1A, 32'hFFFF_FFF0, 32'h0,
               32'hFFFF_FFF0, 32'hFFFF_FFFF, 1);
        op_res("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 0);

        // mthi, then mflo and mfhi back to back
        @(negedge clk);
        drive(1'b1, 6'h11, 32'hA5A5_A5A5, 32'h0);
        #1;
        chk("mthi_nostall", 32'(bus.MulDivStall), 32'd0);
        @(negedge clk);
        drive(1'b1, 6'h12, 32'h0, 32'h0);
        #1;
        chk("mflo_keep", bus.HiLoOut, 32'h8000_0000);
        chk("mflo_nostall", 32'(bus.MulDivStall), 32'd0);
        @(negedge clk);
        drive(1'b1, 6'h10, 32'h0, 32'h0);
        #1;
        chk("mfhi_new", bus.HiLoOut, 32'hA5A5_A5A5);
        chk("mfhi_nostall", 32'(bus.MulDivStall), 32'd0);
        @(negedge clk);
        drive(1'b1, 6'h13, 32'h1357_9BDF, 32'h0);
        @(negedge clk);
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        rd("mtlo", 6'h12, 32'h1357_9BDF);

        // abort a mult with reset partway through its iterations
        @(negedge clk);
        drive(1'b1, 6'h18, 32'h0000_1234, 32'h0000_5678);
        stalls = 0;
        #1;
        while (bus.MulDivStall === 1'b1 && stalls < 11) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk("abort_reached", 32'(stalls), 32'd11);
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 32'd0, 32'd0);
        #1;
        chk("abort_stall_in_rst", 32'(bus.MulDivStall), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_stall", 32'(bus.MulDivStall), 32'd0);
        chk("abort_busy", 32'(bus.MulDivBusy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("abort_hi", 6'h10, 32'd0);
        rd("abort_lo", 6'h12, 32'd0);
        repeat (40) @(negedge clk);
        #1;
        chk("abort_no_done", 32'(bus.DivByZero | bus.MulDivBusy), 32'd0);
        rd("abort_hi2", 6'h10, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
